stack_arbiter: RTL and testbench
================================

STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 32, number of stack entries (power of two); AW = log2(DEPTH).
REQ-003 One clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  2  per-requester request (bit i = requester i).
REQ-007 req_pop  input  2  per-requester op; 1 = pop, 0 = push.
REQ-008 req_data  input  2*WIDTH  push data; requester i uses bits [i*WIDTH +: WIDTH].
REQ-009 req_ready  output  2  one-cycle accept pulse to the granted requester.
REQ-010 rsp_valid  output  2  one-cycle completion pulse to the served requester.
REQ-011 rsp_data  output  WIDTH  popped word; 0 for push or error.
REQ-012 rsp_err  output  1  valid with rsp_valid; overflow or underflow.
REQ-013 mem_we, mem_addr, mem_wdata  output  1/AW/WIDTH  write port to external stack RAM.
REQ-014 mem_rdata  input  WIDTH  combinational read data of external RAM at mem_addr.
REQ-015 full, empty  output  1 each  stack status; level  output  AW+1  current entry count.

Function
REQ-016 FSM states SHALL be IDLE and EXEC; reset state IDLE.
REQ-017 IDLE: if any req_valid bit set, grant one requester, latch its op/data, pulse req_ready[g], go EXEC; else stay.
REQ-018 Arbitration SHALL be round-robin: on both valid, grant the requester not granted last; single valid wins outright.
REQ-019 EXEC push, not full: mem_we=1, mem_addr=sp[AW-1:0], mem_wdata=latched data; sp increments.
REQ-020 EXEC pop, not empty: mem_addr=sp-1, rsp_data registers mem_rdata; sp decrements.
REQ-021 Push when full or pop when empty: no write, sp unchanged, rsp_err=1, rsp_data=0.
REQ-022 EXEC always returns to IDLE; rsp_valid[g], rsp_data, rsp_err registered, asserted in the cycle after EXEC.
REQ-023 Throughput one operation per 2 cycles; a new grant may coincide with the previous rsp_valid.
REQ-024 mem_we SHALL be 0 outside EXEC; mem_addr/mem_wdata are don't-care when not used.
REQ-025 level = sp; full = (sp == DEPTH); empty = (sp == 0); all derived from registered sp.
REQ-026 Requesters hold req_valid/req_pop/req_data stable until req_ready; de-asserting earlier is illegal and unchecked.

Reset
REQ-027 rst_n low SHALL force IDLE, sp=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, mem_we=0, last-grant=1 (requester 0 wins first).
REQ-028 Reset during EXEC SHALL abort the operation with no write and no response; RAM contents are not cleared.

Configuration
REQ-029 Macro STACK_ARB_FIXED_PRIO_EN: defined -> requester 0 always wins simultaneous requests, last-grant register omitted; undefined -> round-robin per REQ-018.

Structure
REQ-030 Package stack_arb_pkg SHALL hold the state enum, op encoding (PUSH=0, POP=1) and WIDTH/DEPTH defaults.
REQ-031 Arbitration SHALL live in sub-module rr_arbiter (2 requests in, one-hot grant out, update strobe); FSM, sp and response registers in stack_arbiter.

Verification
REQ-032 After reset, req0 push 0xA5 -> req_ready[0] at cycle 1, mem_we with addr 0 data 0xA5, rsp_valid[0] err=0, level=1.
REQ-033 Both requesters push together twice (0x11 r0, 0x22 r1) -> grants alternate r0,r1,r0,r1; level=4.
REQ-034 Pop on empty stack -> rsp_err=1, rsp_data=0, no mem_we, level stays 0.
REQ-035 Fill 32 pushes then push 0xFF -> full=1, rsp_err=1, no write; pop returns 32nd pushed word, full=0.
REQ-036 Assert rst_n=0 in EXEC of a push -> no mem_we, no rsp_valid, level=0; with STACK_ARB_FIXED_PRIO_EN both-valid stream grants r0 every time.

Source files
------------

// File: rtl/stack_arb_pkg.sv
// Shared types and defaults for the two-requester stack arbiter.
// Optional feature macro: STACK_ARB_FIXED_PRIO_EN (fixed priority to requester 0).
package stack_arb_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_t;

endpackage

// File: rtl/stack_arbiter_rr_arbiter.sv
// Two-way arbiter producing a one-hot grant; round-robin by default.
// Defining STACK_ARB_FIXED_PRIO_EN makes requester 0 always win and drops the history register.
module rr_arbiter
  import stack_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

`ifdef STACK_ARB_FIXED_PRIO_EN

  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, update};

  always_comb begin
    grant = {req[1] & ~req[0], req[0]};
  end

`else

  // Index of the requester granted most recently; resets to 1 so requester 0 wins first.
  logic last;

  always_comb begin
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (update && (grant != 2'b00)) begin
      last <= grant[1];
    end
  end

`endif

endmodule

// File: rtl/stack_arbiter.sv
// Two-requester push/pop front end for an external single-port stack RAM.
// Optional macro STACK_ARB_FIXED_PRIO_EN selects fixed priority in the arbiter.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  input  logic [1:0]         req_pop,
  input  logic [2*WIDTH-1:0] req_data,
  output logic [1:0]         req_ready,
  output logic [1:0]         rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        level
);

  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] SP_ONE  = (AW+1)'(1);

  state_t           state;
  logic [AW:0]      sp;
  logic [AW:0]      sp_m1;
  logic [1:0]       grant;
  logic [1:0]       gnt_r;
  op_t              op_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] sel_data;
  logic             sel_pop;
  logic             start;
  logic             do_push;
  logic             do_pop;

  assign start = (state == IDLE) && (req_valid != 2'b00);

  rr_arbiter u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .update (start),
    .grant  (grant)
  );

  assign sel_data = grant[1] ? req_data[WIDTH +: WIDTH] : req_data[0 +: WIDTH];
  assign sel_pop  = grant[1] ? req_pop[1] : req_pop[0];

  // Status is derived purely from the registered stack pointer.
  assign level = sp;
  assign full  = (sp == SP_FULL);
  assign empty = (sp == '0);
  assign sp_m1 = sp - SP_ONE;

  assign do_push = (state == EXEC) && (op_r == OP_PUSH) && !full;
  assign do_pop  = (state == EXEC) && (op_r == OP_POP) && !empty;

  // RAM port is driven combinationally in EXEC so a pop reads the top entry in that cycle.
  assign mem_we    = do_push;
  assign mem_addr  = (op_r == OP_POP) ? sp_m1[AW-1:0] : sp[AW-1:0];
  assign mem_wdata = data_r;

  // Operation latch; only consumed while in EXEC, so no reset is needed.
  always_ff @(posedge clk) begin
    if (start) begin
      gnt_r  <= grant;
      op_r   <= op_t'(sel_pop);
      data_r <= sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sp        <= '0;
      req_ready <= 2'b00;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= 2'b00;
      rsp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (start) begin
            req_ready <= grant;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid <= gnt_r;
          rsp_err   <= !(do_push || do_pop);
          rsp_data  <= do_pop ? mem_rdata : '0;
          if (do_push) begin
            sp <= sp + SP_ONE;
          end else if (do_pop) begin
            sp <= sp_m1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter with a behavioural stack RAM and reference stack model.
module tb_stack_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic               clk;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_pop;
  logic [2*WIDTH-1:0] req_data;
  logic [1:0]         req_ready;
  logic [1:0]         rsp_valid;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_err;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [WIDTH-1:0]   mem_wdata;
  logic [WIDTH-1:0]   mem_rdata;
  logic               full;
  logic               empty;
  logic [AW:0]        level;

  stack_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_pop   (req_pop),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External stack RAM: synchronous write, combinational read.
  logic [WIDTH-1:0] ram [DEPTH];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  typedef struct packed {logic [1:0] who; logic [7:0] data; logic err;} rsp_t;
  typedef struct packed {logic [4:0] addr; logic [7:0] data;} wr_t;

  rsp_t exp_q[$];
  wr_t  wr_q[$];
  rsp_t mon_e;
  wr_t  mon_w;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 0;
  int   first_lat;

  logic [7:0] mstk [DEPTH];
  int         msp;
  logic       mlast;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexp_rsp", 32'(rsp_valid), 32'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_who", 32'(rsp_valid), 32'(mon_e.who));
          check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
          check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          check("unexp_we", 32'(mem_we), 32'(0));
        end else begin
          mon_w = wr_q.pop_front();
          check("we_addr", 32'(mem_addr), 32'(mon_w.addr));
          check("we_data", 32'(mem_wdata), 32'(mon_w.data));
        end
      end
    end
  end

  function automatic int pick(input logic [1:0] v);
`ifdef STACK_ARB_FIXED_PRIO_EN
    return v[0] ? 0 : 1;
`else
    if (v == 2'b11) return mlast ? 0 : 1;
    return v[0] ? 0 : 1;
`endif
  endfunction

  task automatic model_op(input int g, input logic pop, input logic [7:0] d);
    rsp_t e;
    e.who = 2'(1 << g);
    e.data = 8'h00;
    e.err = 1'b0;
    if (pop) begin
      if (msp == 0) e.err = 1'b1;
      else begin
        msp--;
        e.data = mstk[msp];
      end
    end else begin
      if (msp == DEPTH) e.err = 1'b1;
      else begin
        wr_q.push_back({5'(msp), d});
        mstk[msp] = d;
        msp++;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] v, input logic [1:0] pop, input logic [15:0] d);
    logic [1:0] pend;
    int g;
    int guard;
    bit first;
    pend = v;
    first = 1;
    req_pop = pop;
    req_data = d;
    req_valid = v;
    while (pend != 2'b00) begin
      g = pick(pend);
      guard = 0;
      do begin
        @(posedge clk); #1;
        guard++;
      end while (req_ready == 2'b00 && guard < 10);
      if (first) first_lat = guard;
      first = 0;
      check("grant", 32'(req_ready), 32'(1) << g);
      model_op(g, pop[g], d[g*8 +: 8]);
      mlast = g[0];
      pend[g] = 1'b0;
      req_valid[g] = 1'b0;
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    check("drain", 32'(exp_q.size()), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_level"}, 32'(level), 32'(msp));
    check({tag, "_full"}, 32'(full), 32'(msp == DEPTH));
    check({tag, "_empty"}, 32'(empty), 32'(msp == 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_level", 32'(level), 32'(0));
    rst_n = 1'b1;
    exp_q.delete();
    wr_q.delete();
    msp = 0;
    mlast = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_pop = 2'b00;
    req_data = '0;
    msp = 0;
    mlast = 1'b1;
    first_lat = 0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));
    check("rst_rsp_err", 32'(rsp_err), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check_status("rst");
    rst_n = 1'b1;
    mon_en = 1;
    @(negedge clk);

    // Single push from requester 0
    issue(2'b01, 2'b00, 16'h00A5);
    check("ready_lat", 32'(first_lat), 32'(1));
    check_status("push1");

    // Simultaneous pushes, twice, then alternation after a lone r0 grant
    do_reset();
    issue(2'b11, 2'b00, 16'h2211);
    issue(2'b11, 2'b00, 16'h2211);
    check_status("both");
    issue(2'b01, 2'b00, 16'h0033);
    issue(2'b11, 2'b00, 16'h5544);
    issue(2'b11, 2'b11, 16'h0000);
    check_status("rr");

    // Underflow
    do_reset();
    issue(2'b01, 2'b01, 16'h0000);
    issue(2'b10, 2'b10, 16'h0000);
    check_status("underflow");

    // Fill to full, overflow, then pop the last pushed word
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      issue((i % 2 == 0) ? 2'b01 : 2'b10, 2'b00, {2{8'(i * 7 + 3)}});
    end
    check_status("filled");
    issue(2'b01, 2'b00, 16'h00FF);
    check_status("overflow");
    issue(2'b10, 2'b10, 16'h0000);
    check_status("after_pop");

    // Mixed random traffic
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 16'($urandom));
    end
    check_status("random");

    // Reset in the middle of a push
    do_reset();
    req_pop = 2'b00;
    req_data = 16'h0077;
    req_valid = 2'b01;
    begin
      int guard;
      guard = 0;
      do begin
        @(posedge clk); #1;
        guard++;
      end while (req_ready == 2'b00 && guard < 10);
      check("abort_grant", 32'(req_ready), 32'(1));
    end
    rst_n = 1'b0;
    req_valid = 2'b00;
    #1;
    check("abort_we", 32'(mem_we), 32'(0));
    repeat (2) @(negedge clk);
    check("abort_rsp", 32'(rsp_valid), 32'(0));
    rst_n = 1'b1;
    msp = 0;
    mlast = 1'b1;
    @(negedge clk);
    check_status("abort");
    issue(2'b11, 2'b00, 16'hBBAA);
    issue(2'b11, 2'b00, 16'hDDCC);
    issue(2'b11, 2'b11, 16'h0000);
    check_status("post_abort");

    repeat (3) @(negedge clk);
    check("final_q", 32'(exp_q.size() + wr_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
